simon_controller: RTL

Sequencing FSM for the Simon game datapath. It turns one-cycle `advance` pulses (debounced user button) and the three datapath status flags into the datapath control strobes and the 3-bit LED mode indicator. It walks the game through pattern entry, playback, repeat-check and game-over. It sits between the button/switch front end and the datapath, on the same clock.

---
 rtl/simon_controller.sv | 139 +++++++++++++
 1 files changed

// File: rtl/simon_controller.sv
// Simon game sequencing FSM: turns advance pulses and datapath status flags
// into datapath control strobes, the LED mode indicator and the win flag.
module simon_controller #(
  parameter int MAX_ROUNDS = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  input  logic       is_legal,
  input  logic       input_eq_pattern,
  input  logic       index_lt_count,
  output logic       w_en,
  output logic       set_level,
  output logic       read_Memory,
  output logic       cnt_count,
  output logic       clr_count,
  output logic       cnt_index,
  output logic       clr_index,
  output logic [2:0] mode_leds,
  output logic       game_won
);

  localparam int RW = $clog2(MAX_ROUNDS) + 1;
  localparam logic [RW-1:0] LAST_ROUND = RW'(MAX_ROUNDS - 1);

  typedef enum logic [1:0] {
    S_INPUT    = 2'd0,
    S_PLAYBACK = 2'd1,
    S_REPEAT   = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [RW-1:0] round_q;
  logic          round_inc;
  logic          won_set;
  logic          won_clr;
  logic          last_round;

  // round_q counts completed rounds; the round being finished is the last when round_q + 1 == MAX_ROUNDS
  assign last_round = (round_q == LAST_ROUND);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_INPUT;
      round_q  <= '0;
      game_won <= 1'b0;
    end else begin
      state <= state_nxt;
      if (round_inc) round_q <= round_q + 1'b1;
      if (won_set)      game_won <= 1'b1;
      else if (won_clr) game_won <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    round_inc = 1'b0;
    won_set   = 1'b0;
    won_clr   = 1'b0;
    if (advance) begin
      case (state)
        S_INPUT: begin
          if (is_legal) state_nxt = S_PLAYBACK;
        end
        S_PLAYBACK: begin
          if (!index_lt_count) state_nxt = S_REPEAT;
        end
        S_REPEAT: begin
          if (!input_eq_pattern) begin
            state_nxt = S_DONE;
            won_clr   = 1'b1;
          end else if (!index_lt_count) begin
            if (last_round) begin
              state_nxt = S_DONE;
              won_set   = 1'b1;
            end else begin
              state_nxt = S_INPUT;
              round_inc = 1'b1;
            end
          end
        end
        default: state_nxt = S_DONE;
      endcase
    end
  end

  always_comb begin
    w_en        = 1'b0;
    set_level   = 1'b0;
    cnt_count   = 1'b0;
    clr_count   = 1'b0;
    cnt_index   = 1'b0;
    clr_index   = 1'b0;
    read_Memory = 1'b0;
    mode_leds   = 3'b001;
    case (state)
      S_INPUT:    begin mode_leds = 3'b001; read_Memory = 1'b0; end
      S_PLAYBACK: begin mode_leds = 3'b010; read_Memory = 1'b1; end
      S_REPEAT:   begin mode_leds = 3'b100; read_Memory = 1'b0; end
      default:    begin mode_leds = 3'b111; read_Memory = 1'b1; end
    endcase
    // Reset wins over advance; it also clears the datapath count/index and latches the level.
    if (reset) begin
      set_level = 1'b1;
      clr_count = 1'b1;
      clr_index = 1'b1;
    end else if (advance) begin
      case (state)
        S_INPUT: begin
          if (is_legal) begin
            w_en      = 1'b1;
            clr_index = 1'b1;
          end
        end
        S_PLAYBACK: begin
          if (index_lt_count) cnt_index = 1'b1;
          else                clr_index = 1'b1;
        end
        S_REPEAT: begin
          if (!input_eq_pattern) begin
            clr_index = 1'b1;
          end else if (index_lt_count) begin
            cnt_index = 1'b1;
          end else begin
            clr_index = 1'b1;
            // On the winning match count stays put so the datapath count never wraps.
            if (!last_round) cnt_count = 1'b1;
          end
        end
        default: begin
          if (index_lt_count) cnt_index = 1'b1;
          else                clr_index = 1'b1;
        end
      endcase
    end
  end

endmodule
